// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM states, dmem RW encodings
// and the word-alignment check used on requester byte addresses.
package dmem_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    localparam logic [1:0] ALIGN_MASK = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return (addr_lsb & ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on contention the requester that did not win last
// time is chosen; a sole requester always wins.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       valid_o,
    output logic       winner_o
);

    always_comb begin
        valid_o  = |req_i;
        winner_o = (req_i == 2'b11) ? ~last_i : req_i[1];
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port dmem between the load/store unit (M0) and a debug/DMA
// loader (M1): IDLE arbitrates and latches, ACCESS drives dmem for one cycle.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int   ADDR_W     = 32,
    parameter int   DATA_W     = 32,
    parameter logic FIRST_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic              mem_RW,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            state_q;
    logic              last_q;
    logic              id_q;
    logic              we_q;
    logic              mis_q;
    logic [1:0]        gnt_q;
    logic [1:0]        rvalid_q;
    logic [1:0]        err_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;
    logic              mem_rw_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic              arb_valid;
    logic              arb_winner;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              win_mis;
    logic              rsp_d;
    logic [DATA_W-1:0] rdata_d;

    rr_arb2 u_arb (
        .req_i    ({m1_req, m0_req}),
        .last_i   (last_q),
        .valid_o  (arb_valid),
        .winner_o (arb_winner)
    );

    always_comb begin
        win_we    = m0_we;
        win_addr  = m0_addr;
        win_wdata = m0_wdata;
        if (arb_winner) begin
            win_we    = m1_we;
            win_addr  = m1_addr;
            win_wdata = m1_wdata;
        end
        win_mis = is_misaligned(win_addr[1:0]);
    end

    // Misaligned accesses answer like a read (rvalid+err) so writers learn of the error.
    always_comb begin
        rsp_d   = (we_q == MEM_READ) || mis_q;
        rdata_d = ((we_q == MEM_READ) && !mis_q) ? mem_rdata : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_q      <= ~FIRST_PRIO;
            id_q        <= 1'b0;
            we_q        <= MEM_READ;
            mis_q       <= 1'b0;
            gnt_q       <= '0;
            rvalid_q    <= '0;
            err_q       <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            mem_rw_q    <= MEM_READ;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            gnt_q    <= '0;
            rvalid_q <= '0;
            err_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (arb_valid) begin
                        id_q              <= arb_winner;
                        we_q              <= win_we;
                        mis_q             <= win_mis;
                        last_q            <= arb_winner;
                        gnt_q[arb_winner] <= 1'b1;
                        mem_rw_q          <= (win_we == MEM_WRITE && !win_mis) ? MEM_WRITE : MEM_READ;
                        mem_addr_q        <= win_addr;
                        mem_wdata_q       <= win_wdata;
                        state_q           <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    rvalid_q[id_q] <= rsp_d;
                    err_q[id_q]    <= mis_q;
                    if (id_q) begin
                        rdata1_q <= rdata_d;
                    end else begin
                        rdata0_q <= rdata_d;
                    end
                    mem_rw_q    <= MEM_READ;
                    mem_addr_q  <= '0;
                    mem_wdata_q <= '0;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign m0_gnt      = gnt_q[0];
    assign m1_gnt      = gnt_q[1];
    assign m0_rvalid   = rvalid_q[0];
    assign m1_rvalid   = rvalid_q[1];
    assign m0_err      = err_q[0];
    assign m1_err      = err_q[1];
    assign m0_rdata    = rdata0_q;
    assign m1_rdata    = rdata1_q;
    assign mem_RW      = mem_rw_q;
    assign mem_address = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter with a behavioural dmem and a transaction-timeline
// reference model (arbitration order, latency and memory contents).
module tb_dmem_arbiter;

    localparam int NCYC       = 8192;
    localparam bit FIRST_PRIO = 1'b0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0;
    logic        m0_gnt, m0_rvalid, m0_err;
    logic [31:0] m0_rdata;
    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m1_addr = '0, m1_wdata = '0;
    logic        m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m1_rdata;
    logic        mem_RW;
    logic [31:0] mem_address, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIRST_PRIO(FIRST_PRIO)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_RW(mem_RW), .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Behavioural dmem: combinational read, write on posedge when RW=1.
    logic [31:0] dmem [0:255];
    always @(posedge clk) if (mem_RW) dmem[mem_address[9:2]] <= mem_wdata;
    assign mem_rdata = dmem[mem_address[9:2]];

    typedef struct {
        bit        we;
        bit [31:0] addr;
        bit [31:0] wdata;
        int        gap;
    } txn_t;

    txn_t q0[$];
    txn_t q1[$];
    txn_t cur [2];
    bit   act [2];
    int   gapc [2];

    bit [31:0] ref_mem [256];
    bit        last;
    int        free_at;
    int        cyc;
    bit        e_gnt [2][NCYC];
    bit        e_rv  [2][NCYC];
    bit        e_err [2][NCYC];
    bit [31:0] e_rd  [2][NCYC];
    bit        e_rw  [NCYC];
    bit        e_busy[NCYC];
    bit [31:0] e_ad  [NCYC];
    bit        wc_v  [NCYC];
    bit [7:0]  wc_i  [NCYC];
    bit [31:0] wc_d  [NCYC];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
    endtask

    task automatic model_reset();
        last    = ~FIRST_PRIO;
        free_at = 0;
        for (int i = 0; i < NCYC; i++) begin
            for (int m = 0; m < 2; m++) begin
                e_gnt[m][i] = 0; e_rv[m][i] = 0; e_err[m][i] = 0; e_rd[m][i] = 0;
            end
            e_rw[i] = 0; e_busy[i] = 0; e_ad[i] = 0; wc_v[i] = 0; wc_i[i] = 0; wc_d[i] = 0;
        end
        act[0] = 0; act[1] = 0; gapc[0] = 0; gapc[1] = 0;
        q0.delete(); q1.delete();
    endtask

    task automatic drive();
        if (!act[0] && q0.size() > 0) begin cur[0] = q0.pop_front(); act[0] = 1; gapc[0] = cur[0].gap; end
        if (!act[1] && q1.size() > 0) begin cur[1] = q1.pop_front(); act[1] = 1; gapc[1] = cur[1].gap; end
        m0_req   = act[0] && gapc[0] == 0;
        m0_we    = m0_req ? cur[0].we : 1'b0;
        m0_addr  = m0_req ? cur[0].addr : '0;
        m0_wdata = m0_req ? cur[0].wdata : '0;
        m1_req   = act[1] && gapc[1] == 0;
        m1_we    = m1_req ? cur[1].we : 1'b0;
        m1_addr  = m1_req ? cur[1].addr : '0;
        m1_wdata = m1_req ? cur[1].wdata : '0;
    endtask

    // One clock: predict the next posedge from the rules, advance, then compare.
    task automatic step();
        int       p;
        bit       w;
        bit       mis;
        bit [1:0] r;
        txn_t     t;
        p = cyc + 1;
        r = {m1_req, m0_req};
        if (p >= free_at && r != 2'b00) begin
            w       = (r == 2'b11) ? ~last : r[1];
            last    = w;
            free_at = p + 2;
            t       = cur[w];
            mis     = t.addr[1:0] != 2'b00;
            e_gnt[w][p] = 1;
            e_busy[p]   = 1;
            e_ad[p]     = t.addr;
            e_rw[p]     = t.we && !mis;
            if (!t.we || mis) begin
                e_rv[w][p+1]  = 1;
                e_err[w][p+1] = mis;
                e_rd[w][p+1]  = mis ? 32'h0 : ref_mem[t.addr[9:2]];
            end else begin
                wc_v[p+1] = 1; wc_i[p+1] = t.addr[9:2]; wc_d[p+1] = t.wdata;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (wc_v[cyc]) ref_mem[wc_i[cyc]] = wc_d[cyc];
        chk("m0_gnt", m0_gnt, e_gnt[0][cyc]);
        chk("m1_gnt", m1_gnt, e_gnt[1][cyc]);
        chk("m0_rvalid", m0_rvalid, e_rv[0][cyc]);
        chk("m1_rvalid", m1_rvalid, e_rv[1][cyc]);
        chk("m0_err", m0_err, e_err[0][cyc]);
        chk("m1_err", m1_err, e_err[1][cyc]);
        if (e_rv[0][cyc]) chk("m0_rdata", m0_rdata, e_rd[0][cyc]);
        if (e_rv[1][cyc]) chk("m1_rdata", m1_rdata, e_rd[1][cyc]);
        chk("mem_RW", mem_RW, e_rw[cyc]);
        chk("mem_address", mem_address, e_ad[cyc]);
        for (int m = 0; m < 2; m++)
            if (act[m] && gapc[m] > 0) gapc[m]--;
        if (act[0] && m0_req && m0_gnt) act[0] = 0;
        if (act[1] && m1_req && m1_gnt) act[1] = 0;
        drive();
    endtask

    function automatic bit pending();
        return act[0] || act[1] || q0.size() > 0 || q1.size() > 0 || cyc < free_at;
    endfunction

    task automatic run_done(input int budget);
        int n = 0;
        drive();
        while (pending() && n < budget) begin
            step();
            n++;
        end
        if (pending()) chk("timeout", 32'd1, 32'd0);
    endtask

    task automatic do_reset();
        model_reset();
        drive();
        #1 rst = 1'b1;
        #1;
        chk("rst_mem_RW", mem_RW, 0);
        chk("rst_mem_address", mem_address, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_gnt", {m1_gnt, m0_gnt}, 0);
        chk("rst_rvalid", {m1_rvalid, m0_rvalid}, 0);
        chk("rst_err", {m1_err, m0_err}, 0);
        chk("rst_m0_rdata", m0_rdata, 0);
        chk("rst_m1_rdata", m1_rdata, 0);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic txn_t mk(input bit we, input bit [31:0] addr, input bit [31:0] wdata, input int gap);
        txn_t t;
        t.we = we; t.addr = addr; t.wdata = wdata; t.gap = gap;
        return t;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        cyc = 0;
        @(negedge clk);
        do_reset();

        // Loader fills every word so later reads have defined contents.
        for (int i = 0; i < 256; i++) q1.push_back(mk(1'b1, i * 4, i * 32'h9E3779B9 + 32'h13, 0));
        run_done(1000);

        q0.push_back(mk(1'b1, 32'h0, 32'hABCDEF00, 0));
        q0.push_back(mk(1'b0, 32'h0, 32'h0, 0));
        run_done(20);

        do_reset();
        q0.push_back(mk(1'b1, 32'h4, 32'hFFFFFFFF, 0));
        q1.push_back(mk(1'b1, 32'h8, 32'h12345678, 0));
        q0.push_back(mk(1'b0, 32'h4, 32'h0, 2));
        q1.push_back(mk(1'b0, 32'h8, 32'h0, 2));
        run_done(40);
        chk("word4", ref_mem[1], 32'hFFFFFFFF);
        chk("word8", ref_mem[2], 32'h12345678);

        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(1'b0, 32'h10 + i * 8, 32'h0, 0));
            q1.push_back(mk(1'b0, 32'h14 + i * 8, 32'h0, 0));
        end
        run_done(40);

        q1.push_back(mk(1'b0, 32'h6, 32'h0, 0));
        q0.push_back(mk(1'b0, 32'h4, 32'h0, 3));
        run_done(20);

        q0.push_back(mk(1'b1, 32'hC, 32'h5A5A5A5A, 0));
        drive();
        n = 0;
        while (!e_gnt[0][cyc] && n < 5) begin
            step();
            n++;
        end
        if (!e_gnt[0][cyc]) chk("rst_access_reached", 32'd0, 32'd1);
        do_reset();
        q0.push_back(mk(1'b0, 32'hC, 32'h0, 0));
        run_done(20);
        chk("lost_write", (ref_mem[3] == 32'h5A5A5A5A), 32'd0);

        for (int i = 0; i < 10; i++) step();

        for (int i = 0; i < 150; i++) begin
            txn_t t;
            t = mk($urandom_range(0, 1), $urandom_range(0, 255) * 4, $urandom, $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) t.addr[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 1) == 1) q0.push_back(t);
            else q1.push_back(t);
        end
        run_done(3000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
